// File: rtl/cla_word_sequencer.sv
// Word-serial multi-word adder built around an 11-bit carry-lookahead adder.
// Carry chains between words; each sum word goes out on a one-entry valid/ready register.

module cla_adder #(
  parameter int W = 11
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);
  logic [W-1:0] w_g, w_p;
  logic [W:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is a flat sum of generate terms propagated through the bits above them.
  always_comb begin
    logic term;
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 1; i <= W; i++) begin
      for (int j = -1; j < i; j++) begin
        term = (j < 0) ? i_cin : w_g[j];
        for (int k = j + 1; k < i; k++) term = term & w_p[k];
        w_c[i] = w_c[i] | term;
      end
    end
  end

  assign o_sum  = w_p ^ w_c[W-1:0];
  assign o_cout = w_c[W];
endmodule

module cla_word_sequencer #(
  parameter int MAX_WORDS = 8,
  parameter int IDX_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      in_a,
  input  logic [10:0]      in_b,
  input  logic             in_cin,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_sum,
  output logic             out_cout,
  output logic             out_last,
  output logic             out_trunc,
  output logic [IDX_W-1:0] out_idx
);
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_carry, w_carry_nxt;

  logic [10:0]      w_sum;
  logic             w_cout, w_cin, w_accept, w_at_max, w_lastw;

  logic             r_out_valid, r_out_cout, r_out_last, r_out_trunc;
  logic [10:0]      r_out_sum;
  logic [IDX_W-1:0] r_out_idx;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready && !abort;
  assign w_at_max = (r_cnt == IDX_W'(MAX_WORDS - 1));
  assign w_lastw  = in_last || w_at_max;
  // in_cin only seeds the first word; later words chain the stored carry.
  assign w_cin    = (r_state == S_BUSY) ? r_carry : in_cin;

  cla_adder #(.W(11)) u_add (
    .i_a   (in_a),
    .i_b   (in_b),
    .i_cin (w_cin),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_carry_nxt = r_carry;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_carry_nxt = 1'b0;
    end else if (w_accept) begin
      if (w_lastw) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_carry_nxt = 1'b0;
      end else begin
        w_state_nxt = S_BUSY;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_carry_nxt = w_cout;
      end
    end
  end

  // Abort drops a pending word but leaves the data fields as they were.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_trunc <= 1'b0;
      r_out_idx   <= '0;
    end else if (abort) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum;
      r_out_cout  <= w_cout;
      r_out_last  <= w_lastw;
      r_out_trunc <= !in_last && w_at_max;
      r_out_idx   <= r_cnt;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_last  = r_out_last;
  assign out_trunc = r_out_trunc;
  assign out_idx   = r_out_idx;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Vector table plus hand sequences for backpressure, abort and async reset; outputs
// are checked against a queue of expected words pushed when each input is accepted.

module tb_cla_word_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, abort, in_valid, in_ready, in_cin, in_last;
  logic [10:0] in_a, in_b, out_sum;
  logic        out_valid, out_ready, out_cout, out_last, out_trunc;
  logic [5:0]  out_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [10:0] a, b;
    logic        cin, last;
    logic [10:0] sum;
    logic        cout, elast, trunc;
    logic [5:0]  idx;
  } vec_t;

  typedef struct {
    logic [10:0] sum;
    logic        cout, elast, trunc;
    logic [5:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[13];

  cla_word_sequencer #(.MAX_WORDS(4), .IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_last(out_last),
    .out_trunc(out_trunc), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Output monitor: every completed output handshake consumes one expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_word: unexpected word sum=%h idx=%0d", out_sum, out_idx);
      end else begin
        e = exp_q.pop_front();
        if ({out_sum, out_cout, out_last, out_trunc, out_idx} !==
            {e.sum, e.cout, e.elast, e.trunc, e.idx}) begin
          errors++;
          $display("FAIL out_word: got sum=%h cout=%b last=%b trunc=%b idx=%0d, want sum=%h cout=%b last=%b trunc=%b idx=%0d",
                   out_sum, out_cout, out_last, out_trunc, out_idx,
                   e.sum, e.cout, e.elast, e.trunc, e.idx);
        end
      end
    end
  end

  function automatic vec_t mk(input logic [10:0] a, b, input logic cin, last,
                              input logic [10:0] sum, input logic cout, elast, trunc,
                              input logic [5:0] idx);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.last = last;
    v.sum = sum; v.cout = cout; v.elast = elast; v.trunc = trunc; v.idx = idx;
    return v;
  endfunction

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.sum = v.sum; e.cout = v.cout; e.elast = v.elast; e.trunc = v.trunc; e.idx = v.idx;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v);
    bit ok = 0;
    in_a = v.a; in_b = v.b; in_cin = v.cin; in_last = v.last; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (ok) exp_q.push_back(to_exp(v));
    else begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0, want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_zero_outputs(input string name);
    check(name, {out_valid, out_sum, out_cout, out_last, out_trunc, out_idx, in_ready},
          {1'b0, 11'h0, 1'b0, 1'b0, 1'b0, 6'h0, 1'b1});
  endtask

  initial begin
    tbl[0]  = mk(11'h7FF, 11'h001, 1, 1, 11'h001, 1, 1, 0, 0) ; // cin=1 single word
    tbl[1]  = mk(11'h7FF, 11'h001, 0, 1, 11'h000, 1, 1, 0, 0);
    tbl[2]  = mk(11'h7FF, 11'h001, 0, 0, 11'h000, 1, 0, 0, 0);
    tbl[3]  = mk(11'h000, 11'h000, 0, 1, 11'h001, 0, 1, 0, 1);
    tbl[4]  = mk(11'h000, 11'h000, 1, 1, 11'h001, 0, 1, 0, 0);
    tbl[5]  = mk(11'h400, 11'h400, 0, 0, 11'h000, 1, 0, 0, 0);
    tbl[6]  = mk(11'h400, 11'h400, 0, 0, 11'h001, 1, 0, 0, 1);
    tbl[7]  = mk(11'h400, 11'h400, 0, 0, 11'h001, 1, 0, 0, 2);
    tbl[8]  = mk(11'h400, 11'h400, 0, 0, 11'h001, 1, 1, 1, 3);
    tbl[9]  = mk(11'h000, 11'h000, 1, 1, 11'h001, 0, 1, 0, 0);
    tbl[10] = mk(11'h123, 11'h456, 1, 0, 11'h57A, 0, 0, 0, 0);
    tbl[11] = mk(11'h7FF, 11'h7FF, 1, 1, 11'h7FE, 1, 1, 0, 1);   // busy: in_cin ignored
    tbl[12] = mk(11'h2AA, 11'h555, 0, 1, 11'h7FF, 0, 1, 0, 0);

    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_last = 1'b0;
    #12;
    check_zero_outputs("reset_state");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) send(tbl[i]);
    drain();

    // Backpressure: w0 parks in the output register while w1 waits.
    out_ready = 1'b0;
    send(mk(11'h7FF, 11'h001, 0, 0, 11'h000, 1, 0, 0, 0));
    in_a = 11'h000; in_b = 11'h000; in_cin = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_hold", {in_ready, out_valid, out_sum, out_cout, out_last, out_idx},
            {1'b0, 1'b1, 11'h000, 1'b1, 1'b0, 6'd0});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1);
    if (in_ready) exp_q.push_back(to_exp(mk(0, 0, 0, 0, 11'h001, 0, 1, 0, 1)));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Abort wins over a word presented in the same cycle.
    send(mk(11'h001, 11'h002, 0, 0, 11'h003, 0, 0, 0, 0));
    in_a = 11'h004; in_b = 11'h004; in_cin = 1'b0; in_last = 1'b0;
    in_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("abort_valid", out_valid, 0);
    @(posedge clk); #1;
    send(mk(11'h005, 11'h003, 0, 1, 11'h008, 0, 1, 0, 0));
    drain();

    // Abort also drops a word stuck under backpressure.
    out_ready = 1'b0;
    send(mk(11'h010, 11'h020, 0, 0, 11'h030, 0, 0, 0, 0));
    void'(exp_q.pop_back());
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("abort_drop_valid", out_valid, 0);
    @(posedge clk); #1;
    send(mk(11'h001, 11'h001, 1, 1, 11'h003, 0, 1, 0, 0));
    drain();

    // Async reset between edges mid-operand; carry must not survive.
    send(mk(11'h7FF, 11'h001, 0, 0, 11'h000, 1, 0, 0, 0));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(mk(11'h001, 11'h001, 0, 1, 11'h002, 0, 1, 0, 0));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
